iob_axis2axi_wr: RTL and testbench
==================================

Name: iob_axis2axi_wr

Overview:
- Stream-to-memory write engine: accepts a programmed transfer (start address, beat count) and moves AXI-Stream beats into AXI4 write bursts.
- Successor to the single-width stream-in unit:
  - data width generalised to 32/64/128 bits;
  - burst ceiling is parametrised;
  - the stream can end early on tlast;
  - write responses are checked;
  - completion is signalled.
- Sits between a DMA/stream producer and the system AXI interconnect.

Parameters:
- AXI_ADDR_W, 32, address width (>=13 enables 4 KB boundary split).
- AXI_DATA_W, 32, data width; 32, 64 or 128.
- AXI_LEN_W, 8, awlen width.
- AXI_ID_W, 1, id width.
- BURST_W, 4, max burst = 2^BURST_W beats; BURST_W <= AXI_LEN_W.
- XFER_W, 16, width of the programmed beat count.

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; all state holds when 0.
- arst_n_i  in  1  asynchronous active-low reset.
- config_addr_i  in  AXI_ADDR_W  start byte address, aligned to AXI_DATA_W/8.
- config_len_i  in  XFER_W  beats to write; 0 is treated as 1.
- config_valid_i  in  1  config handshake.
- config_ready_o  out  1  high only in IDLE.
- axis_in_data_i  in  AXI_DATA_W  stream data.
- axis_in_last_i  in  1  stream end.
- axis_in_valid_i  in  1  stream valid.
- axis_in_ready_o  out  1  stream ready.
- done_o  out  1  one-cycle pulse at transfer completion.
- error_o  out  1  sticky; any bresp != OKAY; cleared on next config accept.
- beats_o  out  XFER_W  beats written and acknowledged in the current/last transfer.
- axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}_o  out  AXI4 widths  write address channel.
- axi_awready_i  in  1.
- axi_w{data,strb,last,valid}_o  out  AXI4 widths  write data channel.
- axi_wready_i  in  1.
- axi_b{id,resp,valid}_i  in  AXI4 widths.
- axi_bready_o  out  1.

Behaviour:
- Constant outputs:
  - awid = 0;
  - awsize = log2(AXI_DATA_W/8);
  - awburst = INCR;
  - awlock = 0; awcache = 2; awprot = 2; awqos = 0;
  - wstrb = all ones;
  - bready = 1.
- Reset:
  - state IDLE;
  - awvalid, wvalid, wlast, done_o, error_o = 0;
  - beats_o = 0;
  - buffer empty.
- Buffer: internal synchronous FIFO, 2^(BURST_W+1) words, level width BURST_W+2.
- axis_in_ready_o = !full && accepting.
  - accepting is set on config accept.
  - accepting clears when received == config_len, or when a beat with tlast is accepted.
  - Beats offered while not accepting are not consumed.
- remaining = beats received but not yet issued into an AW.
- to4k = (4096 - addr[11:0]) >> log2(AXI_DATA_W/8); omitted when AXI_ADDR_W < 13.
- target = min(2^BURST_W, to4k).
- A burst is issued when either:
  - level >= target; burst length = target; or
  - input has finished (accepting == 0) and level > 0; burst length = min(level, target).
- FSM states:
  - IDLE: config_ready_o = 1. On config handshake: latch addr/len, clear error_o and beats_o, set accepting, go to WAIT_DATA.
  - WAIT_DATA: when the issue condition holds, latch awlen = burst length - 1, go to ADDR.
  - ADDR: awvalid = 1, held stable until awready. Then go to DATA.
  - DATA: wvalid = 1 every cycle; the FIFO holds at least awlen+1 words.
    - The first word is prefetched on ADDR entry so wdata is valid with wvalid; no bubble beats.
    - wlast asserts on beat count == awlen.
    - On wlast handshake: addr += (awlen+1) << awsize. Go to RESP.
  - RESP: wait for bvalid.
    - error_o |= (bresp != 0).
    - beats_o += awlen+1.
    - If accepting == 0 and level == 0: go to DONE. Otherwise go to WAIT_DATA.
  - DONE: done_o = 1 for one cycle, then IDLE.
- Exactly one outstanding burst; no AW is issued before the previous B is received.
- Simultaneous FIFO push and pop in the same cycle: level unchanged.
- Simultaneous tlast and count-reached: a single end event.
- Early tlast: beats_o reports the actual count.
- config_valid_i outside IDLE is ignored.
- Reset mid-burst:
  - all outputs return to reset values immediately (asynchronous);
  - buffered data is discarded;
  - the slave-side burst is abandoned.

Test Plan:
- Config addr 0x1000, len 16, DATA_W 32, BURST_W 4; stream 16 beats 0..15 -> one AW (addr 0x1000, len 15, size 2), 16 W beats in order, wlast on beat 15, done_o pulse, beats_o = 16, error_o = 0.
- Addr 0x0FF8, len 8, DATA_W 64 -> AW0 at 0xFF8 len 0; AW1 at 0x1000 len 6; 8 beats total; no burst crosses 4 KB.
- Len 100, tlast on beat 37 -> bursts 16, 16, 5; beats_o = 37; the beat offered after tlast is not consumed.
- Random wready/awready stalls plus valid gaps on axis_in, len 50 -> data order preserved, awaddr/awlen stable while awvalid is high, done_o once.
- Slave returns bresp = SLVERR on burst 2 of 3 -> error_o = 1 after that B and remains 1 through done. The next config accept clears it.
- Assert arst_n_i mid-DATA, release, new config len 4 at 0x2000 -> clean AW 0x2000 len 3; no stale data.

Source files
------------

// File: rtl/iob_axis2axi_wr_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iob_axis2axi_wr_if - AXI4 write channel bundle (AW, W, B). Rev 1.0
// ----------------------------------------------------------------------------
interface iob_axis2axi_wr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 1
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/iob_axis2axi_wr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iob_axis2axi_wr - AXI-Stream to AXI4 burst write engine with 4 KB split. Rev 1.0
// ----------------------------------------------------------------------------
module iob_axis2axi_wr #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int BURST_W    = 4,
  parameter int XFER_W     = 16
) (
  input  wire                   clk_i,
  input  wire                   cke_i,
  input  wire                   arst_n_i,
  input  wire [AXI_ADDR_W-1:0]  config_addr_i,
  input  wire [XFER_W-1:0]      config_len_i,
  input  wire                   config_valid_i,
  output logic                  config_ready_o,
  input  wire [AXI_DATA_W-1:0]  axis_in_data_i,
  input  wire                   axis_in_last_i,
  input  wire                   axis_in_valid_i,
  output logic                  axis_in_ready_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [XFER_W-1:0]     beats_o,
  iob_axis2axi_wr_if.master     axi
);
  localparam int SIZE  = $clog2(AXI_DATA_W / 8);
  localparam int DEPTH = 2 ** (BURST_W + 1);
  localparam int PTR_W = BURST_W + 1;
  localparam int LVL_W = BURST_W + 2;
  localparam int CMP_W = (LVL_W > 14) ? LVL_W : 14;
  localparam logic [CMP_W-1:0] MAX_BURST = CMP_W'(2 ** BURST_W);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, ADDR, DATA, RESP, DONE} state_t;
  state_t state, state_nxt;

  logic [AXI_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [AXI_ADDR_W-1:0] addr;
  logic [XFER_W-1:0]     xfer_len, received;
  logic                  accepting;
  logic [AXI_LEN_W-1:0]  awlen, beat_cnt;
  logic [CMP_W-1:0]      to4k, target, level_c, burst_len;
  logic                  issue, push, pop, cfg_hs, b_hs, last_beat, full;
  logic                  unused_bid;

  generate
    if (AXI_ADDR_W >= 13) begin : g_4k_split
      logic [12:0] bytes_to4k;
      assign bytes_to4k = 13'd4096 - {1'b0, addr[11:0]};
      assign to4k       = CMP_W'(bytes_to4k >> SIZE);
    end else begin : g_4k_none
      assign to4k = MAX_BURST;
    end
  endgenerate

  assign level_c = CMP_W'(level);
  assign target  = (to4k < MAX_BURST) ? to4k : MAX_BURST;

  // Full bursts go out as soon as enough words are buffered; the tail drains once input ends.
  always_comb begin
    issue     = 1'b0;
    burst_len = target;
    if (level_c >= target) begin
      issue = 1'b1;
    end else if (!accepting && level != '0) begin
      issue     = 1'b1;
      burst_len = level_c;
    end
  end

  assign full            = (level == LVL_W'(DEPTH));
  assign axis_in_ready_o = !full && accepting;
  assign push      = cke_i && axis_in_valid_i && axis_in_ready_o;
  assign pop       = cke_i && (state == DATA) && axi.wready;
  assign cfg_hs    = cke_i && (state == IDLE) && config_valid_i;
  assign b_hs      = cke_i && (state == RESP) && axi.bvalid;
  assign last_beat = axis_in_last_i || (received + XFER_W'(1) == xfer_len);

  assign config_ready_o = (state == IDLE);
  assign done_o         = (state == DONE);
  assign axi.awvalid    = (state == ADDR);
  assign axi.wvalid     = (state == DATA);
  assign axi.wlast      = (state == DATA) && (beat_cnt == awlen);
  assign axi.wdata      = mem[rd_ptr];
  assign axi.awaddr     = addr;
  assign axi.awlen      = awlen;
  assign axi.awid       = '0;
  assign axi.awsize     = 3'(SIZE);
  assign axi.awburst    = 2'b01;
  assign axi.awlock     = 1'b0;
  assign axi.awcache    = 4'b0010;
  assign axi.awprot     = 3'b010;
  assign axi.awqos      = 4'b0000;
  assign axi.wstrb      = '1;
  assign axi.bready     = 1'b1;
  assign unused_bid     = ^axi.bid;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else if (cke_i) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (config_valid_i) state_nxt = WAIT_DATA;
      WAIT_DATA: if (issue) state_nxt = ADDR;
      ADDR:      if (axi.awready) state_nxt = DATA;
      DATA:      if (axi.wready && axi.wlast) state_nxt = RESP;
      RESP:      if (axi.bvalid) state_nxt = (!accepting && level == '0) ? DONE : WAIT_DATA;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= axis_in_data_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      addr      <= '0;
      xfer_len  <= '0;
      received  <= '0;
      accepting <= 1'b0;
      awlen     <= '0;
      beat_cnt  <= '0;
      error_o   <= 1'b0;
      beats_o   <= '0;
    end else if (cke_i) begin
      if (cfg_hs) begin
        addr      <= config_addr_i;
        xfer_len  <= (config_len_i == '0) ? XFER_W'(1) : config_len_i;
        received  <= '0;
        accepting <= 1'b1;
        error_o   <= 1'b0;
        beats_o   <= '0;
      end
      if (push) begin
        received <= received + XFER_W'(1);
        if (last_beat) accepting <= 1'b0;
      end
      if (state == WAIT_DATA && issue) awlen <= AXI_LEN_W'(burst_len - CMP_W'(1));
      if (state == ADDR) beat_cnt <= '0;
      if (pop) begin
        beat_cnt <= beat_cnt + AXI_LEN_W'(1);
        if (axi.wlast) addr <= addr + ((AXI_ADDR_W'(awlen) + AXI_ADDR_W'(1)) << SIZE);
      end
      if (b_hs) begin
        if (axi.bresp != 2'b00) error_o <= 1'b1;
        beats_o <= beats_o + XFER_W'(awlen) + XFER_W'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_iob_axis2axi_wr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_iob_axis2axi_wr - directed bench: stream producer plus behavioural AXI write slave. Rev 1.0
// ----------------------------------------------------------------------------
module tb_iob_axis2axi_wr;
  localparam int AW = 32, DW = 32, LW = 8, IW = 1, BW = 4, XW = 16;

  logic          clk = 1'b0;
  logic          cke, arst_n;
  logic [AW-1:0] config_addr;
  logic [XW-1:0] config_len;
  logic          config_valid, config_ready;
  logic [DW-1:0] axis_data;
  logic          axis_last, axis_valid, axis_ready;
  logic          done, error;
  logic [XW-1:0] beats;

  always #5 clk = ~clk;

  iob_axis2axi_wr_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) axi ();

  iob_axis2axi_wr #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW), .BURST_W(BW), .XFER_W(XW)
  ) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n),
    .config_addr_i(config_addr), .config_len_i(config_len),
    .config_valid_i(config_valid), .config_ready_o(config_ready),
    .axis_in_data_i(axis_data), .axis_in_last_i(axis_last),
    .axis_in_valid_i(axis_valid), .axis_in_ready_o(axis_ready),
    .done_o(done), .error_o(error), .beats_o(beats), .axi(axi)
  );

  int n_checks = 0, n_fail = 0;
  int outstanding = 0, b_idx = 0, err_at = -1, done_cnt = 0;
  bit err_seen = 0, stall_en = 0, b_pend = 0, aw_wait = 0;
  logic [AW-1:0] aw_saved_addr;
  logic [LW-1:0] aw_saved_len;
  logic [AW-1:0] aw_addr_q[$], exp_addr[$];
  logic [LW-1:0] aw_len_q[$], exp_len[$];
  logic [DW-1:0] w_data_q[$], exp_data[$];
  bit            w_last_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (done) done_cnt++;

  // Slave decisions are made at the falling edge and take effect at the next rising edge.
  always @(negedge clk) begin
    if (!arst_n) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      b_pend = 0; aw_wait = 0; outstanding = 0;
    end else begin
      axi.awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      axi.wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (axi.bvalid) begin
        axi.bvalid = 1'b0;
        outstanding--;
        check("error_after_b", error, err_seen);
      end else if (b_pend) begin
        b_pend = 0;
        check("bready", axi.bready, 1);
        axi.bvalid = 1'b1;
        axi.bresp  = (b_idx == err_at) ? 2'b10 : 2'b00;
        if (b_idx == err_at) err_seen = 1;
        b_idx++;
      end
      if (axi.awvalid) begin
        if (aw_wait) begin
          check("aw_addr_stable", axi.awaddr, aw_saved_addr);
          check("aw_len_stable", axi.awlen, aw_saved_len);
        end
        if (axi.awready) begin
          check("aw_one_outstanding", outstanding, 0);
          check("aw_size", axi.awsize, 2);
          check("aw_burst", axi.awburst, 1);
          aw_addr_q.push_back(axi.awaddr);
          aw_len_q.push_back(axi.awlen);
          outstanding++;
          aw_wait = 0;
        end else begin
          aw_wait = 1; aw_saved_addr = axi.awaddr; aw_saved_len = axi.awlen;
        end
      end
      if (axi.wvalid && axi.wready) begin
        w_data_q.push_back(axi.wdata);
        w_last_q.push_back(axi.wlast);
        if (axi.wlast) b_pend = 1;
      end
    end
  end

  task automatic clear_all();
    aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
    exp_addr.delete(); exp_len.delete(); exp_data.delete();
    b_idx = 0; err_at = -1; err_seen = 0;
  endtask

  task automatic do_config(input logic [AW-1:0] a, input logic [XW-1:0] l);
    int cyc = 0;
    @(negedge clk);
    config_addr = a; config_len = l; config_valid = 1'b1;
    while (!config_ready && cyc < 100) begin @(negedge clk); cyc++; end
    check("config_accept", config_ready, 1);
    @(negedge clk);
    config_valid = 1'b0;
  endtask

  task automatic send_stream(input int n, input logic [DW-1:0] base, input int last_at, input bit gaps);
    int i = 0, cyc = 0;
    while (i < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        axis_valid = 1'b0;
      end else begin
        axis_valid = 1'b1; axis_data = base + DW'(i); axis_last = (i == last_at);
      end
      if (axis_valid && axis_ready) i++;
    end
    @(negedge clk);
    axis_valid = 1'b0; axis_last = 1'b0;
    check("stream_beats_taken", i, n);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin @(negedge clk); cyc++; end
    repeat (6) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic verify(input string tag);
    int k = 0, rem;
    check({tag, "_aw_count"}, aw_addr_q.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < aw_addr_q.size(); i++) begin
      check({tag, "_awaddr"}, aw_addr_q[i], exp_addr[i]);
      check({tag, "_awlen"}, aw_len_q[i], exp_len[i]);
    end
    check({tag, "_w_count"}, w_data_q.size(), exp_data.size());
    rem = (exp_len.size() > 0) ? int'(exp_len[0]) + 1 : 0;
    for (int i = 0; i < exp_data.size() && i < w_data_q.size(); i++) begin
      check({tag, "_wdata"}, w_data_q[i], exp_data[i]);
      rem--;
      check({tag, "_wlast"}, w_last_q[i], rem == 0);
      if (rem == 0) begin
        k++;
        rem = (k < exp_len.size()) ? int'(exp_len[k]) + 1 : 0;
      end
    end
  endtask

  task automatic fill_data(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(base + DW'(i));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, cnt, cyc;
    cke = 1'b1; arst_n = 1'b0; config_valid = 1'b0; config_addr = '0; config_len = '0;
    axis_valid = 1'b0; axis_data = '0; axis_last = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
    repeat (3) @(negedge clk);
    check("rst_config_ready", config_ready, 1);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_wlast", axi.wlast, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_beats", beats, 0);
    check("rst_axis_ready", axis_ready, 0);
    check("const_awcache", axi.awcache, 2);
    check("const_awprot", axi.awprot, 2);
    check("const_wstrb", axi.wstrb, 4'hF);
    arst_n = 1'b1;

    // Single full burst; a config offered while busy must be ignored.
    clear_all(); d0 = done_cnt;
    do_config(32'h1000, 16);
    check("t1_error_cleared", error, 0);
    config_valid = 1'b1; config_addr = 32'h9000; config_len = 3;
    repeat (3) @(negedge clk);
    check("t1_busy_config_ready", config_ready, 0);
    config_valid = 1'b0;
    send_stream(16, 32'hA000, -1, 0);
    wait_done(d0, "t1");
    exp_addr = '{32'h1000}; exp_len = '{8'd15}; fill_data(32'hA000, 16);
    verify("t1");
    check("t1_beats", beats, 16);
    check("t1_error", error, 0);

    // 4 KB boundary: 2 beats fit below 0x1000, the remaining 6 follow.
    clear_all(); d0 = done_cnt;
    do_config(32'h0FF8, 8);
    send_stream(8, 32'hB000, -1, 0);
    wait_done(d0, "t2");
    exp_addr = '{32'h0FF8, 32'h1000}; exp_len = '{8'd1, 8'd5}; fill_data(32'hB000, 8);
    verify("t2");
    check("t2_beats", beats, 8);

    // Early tlast on beat 37 of 100; the following beat must not be consumed.
    clear_all(); d0 = done_cnt;
    do_config(32'h3000, 100);
    send_stream(37, 32'hC000, 36, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      axis_valid = 1'b1; axis_data = 32'hDEAD;
      if (axis_ready) cnt++;
    end
    @(negedge clk);
    axis_valid = 1'b0;
    check("t3_post_tlast_taken", cnt, 0);
    wait_done(d0, "t3");
    exp_addr = '{32'h3000, 32'h3040, 32'h3080}; exp_len = '{8'd15, 8'd15, 8'd4};
    fill_data(32'hC000, 37);
    verify("t3");
    check("t3_beats", beats, 37);

    // Random slave stalls and stream gaps; tlast coincides with the programmed count.
    clear_all(); d0 = done_cnt; stall_en = 1;
    do_config(32'h4000, 50);
    send_stream(50, 32'hD000, 49, 1);
    wait_done(d0, "t4");
    stall_en = 0;
    exp_addr = '{32'h4000, 32'h4040, 32'h4080, 32'h40C0};
    exp_len = '{8'd15, 8'd15, 8'd15, 8'd1};
    fill_data(32'hD000, 50);
    verify("t4");
    check("t4_beats", beats, 50);

    // SLVERR on the second of three bursts; sticky until the next config accept.
    clear_all(); d0 = done_cnt; err_at = 1;
    do_config(32'h5000, 48);
    send_stream(48, 32'h1100, -1, 0);
    wait_done(d0, "t5");
    exp_addr = '{32'h5000, 32'h5040, 32'h5080}; exp_len = '{8'd15, 8'd15, 8'd15};
    fill_data(32'h1100, 48);
    verify("t5");
    check("t5_error_sticky", error, 1);
    check("t5_beats", beats, 48);

    // Zero length behaves as one beat; accept clears the error flag.
    clear_all(); d0 = done_cnt;
    do_config(32'h6000, 0);
    check("t5b_error_cleared", error, 0);
    check("t5b_beats_cleared", beats, 0);
    send_stream(1, 32'hE000, -1, 0);
    wait_done(d0, "t5b");
    exp_addr = '{32'h6000}; exp_len = '{8'd0}; fill_data(32'hE000, 1);
    verify("t5b");
    check("t5b_beats", beats, 1);

    // Reset in the middle of a data burst, then a clean short transfer.
    clear_all();
    do_config(32'h7000, 16);
    send_stream(16, 32'hF000, -1, 0);
    cyc = 0;
    while (w_data_q.size() < 4 && cyc < 200) begin @(negedge clk); cyc++; end
    check("t6_in_data_phase", axi.wvalid, 1);
    arst_n = 1'b0;
    #1;
    check("t6_rst_awvalid", axi.awvalid, 0);
    check("t6_rst_wvalid", axi.wvalid, 0);
    check("t6_rst_wlast", axi.wlast, 0);
    check("t6_rst_config_ready", config_ready, 1);
    check("t6_rst_axis_ready", axis_ready, 0);
    check("t6_rst_beats", beats, 0);
    repeat (3) @(negedge clk);
    clear_all();
    arst_n = 1'b1;
    d0 = done_cnt;
    do_config(32'h2000, 4);
    send_stream(4, 32'h5A00, -1, 0);
    wait_done(d0, "t6");
    exp_addr = '{32'h2000}; exp_len = '{8'd3}; fill_data(32'h5A00, 4);
    verify("t6");
    check("t6_beats", beats, 4);
    check("t6_error", error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
